// File: rtl/reg_bank_read_if.sv
// Register-bank bus: write port, two read ports and the operand-latch controls.
interface reg_bank_read_if;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic        ALoad;
  logic        BLoad;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [31:0] AOut;
  logic [31:0] BOut;

  // Datapath control side drives indices, write data and load enables.
  modport master (
    output RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2, ALoad, BLoad,
    input  ReadData1, ReadData2, AOut, BOut
  );

  // Register bank side.
  modport slave (
    input  RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2, ALoad, BLoad,
    output ReadData1, ReadData2, AOut, BOut
  );
endinterface

// File: rtl/reg_bank_read.sv
// 32x32 register file with two combinational read ports and registered
// operand latches A/B. Register 0 reads zero; register 29 resets to SP_RESET.
module reg_bank_read #(
  parameter logic [31:0] SP_RESET = 32'd227
) (
  input  logic           clk,
  input  logic           reset,
  reg_bank_read_if.slave bus
);

  localparam int unsigned NREGS  = 32;
  localparam int unsigned DW     = 32;
  localparam int unsigned AW     = 5;
  localparam int unsigned SP_IDX = 29;

  logic [DW-1:0] regs [NREGS];

  // Register array: reset pattern, otherwise write any nonzero index.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs[i] <= '0;
      end
      regs[SP_IDX] <= SP_RESET;
    end else if (bus.RegWrite && (bus.WriteReg != AW'(0))) begin
      regs[bus.WriteReg] <= bus.WriteData;
    end
  end

  // Read ports see the array before any pending write (no bypass).
  assign bus.ReadData1 = (bus.ReadReg1 == AW'(0)) ? DW'(0) : regs[bus.ReadReg1];
  assign bus.ReadData2 = (bus.ReadReg2 == AW'(0)) ? DW'(0) : regs[bus.ReadReg2];

  // Operand latches capture the pre-write read data when enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.AOut <= '0;
      bus.BOut <= '0;
    end else begin
      if (bus.ALoad) bus.AOut <= bus.ReadData1;
      if (bus.BLoad) bus.BOut <= bus.ReadData2;
    end
  end

endmodule
